warmboot_sequencer: RTL and testbench
=====================================

# warmboot_sequencer

Fabric-side controller for the south-edge warm-boot BEL: qualifies a user boot request (BOOT plus 4-bit SLOT), hands the selected slot to the configuration controller over a req/ack handshake, tracks the CONFIGURED handshake through the reload, and holds the user fabric in reset until the new image is up. It sits between the WARMBOOT BEL outputs and the BOOT_top/SLOT_top/RESET_top top-level nets.

## Interface
- HOLD_CYCLES, 16: consecutive cycles boot_i must be high to qualify a request (>=1)
- RST_CYCLES, 8: cycles fabric reset stays asserted after configured_i returns high (>=1)
- TIMEOUT_CYCLES, 1048576: max cycles waited in each CONFIGURED phase (timeout build only)
- SLOT_W, 4: slot index width
- UserCLK  in  1  single clock; all logic rising-edge
- RESET  in  1  reset, synchronous, active-high
- boot_i  in  1  fabric boot request (BEL BOOT)
- slot_i  in  SLOT_W  requested image slot (BEL SLOT)
- cfg_req_o  out  1  reconfiguration request to config controller (drives BOOT_top)
- cfg_slot_o  out  SLOT_W  slot for the request (drives SLOT_top)
- cfg_ack_i  in  1  config controller accepted request
- configured_i  in  1  CONFIGURED_top
- fabric_rst_o  out  1  user fabric reset (drives RESET_top / BEL RESET)
- busy_o  out  1  sequence in progress
- error_o  out  1  sticky timeout flag
- last_slot_o  out  SLOT_W  slot of last accepted request

## Operation
- States: BOOTUP, IDLE, ARM, REQ, WAIT_DOWN, WAIT_UP, RELEASE (+ ERROR in timeout build).
- Reset values: state BOOTUP, cfg_req_o 0, cfg_slot_o 0, fabric_rst_o 1, busy_o 1, error_o 0, last_slot_o 0, rearm flag 0.
- BOOTUP: wait configured_i=1 (no timeout) -> RELEASE.
- IDLE: busy_o 0, fabric_rst_o 0. Rearm flag sets on any cycle with boot_i=0. boot_i=1 with rearm set -> ARM, hold counter = 1.
- ARM: boot_i=0 -> IDLE, counter cleared. Counter reaching HOLD_CYCLES with boot_i=1 -> latch slot_i into cfg_slot_o and last_slot_o, clear rearm, -> REQ.
- REQ: cfg_req_o=1, fabric_rst_o=1, busy_o=1; cfg_slot_o stable. cfg_ack_i=1 sampled -> WAIT_DOWN; cfg_req_o low the following cycle. Ack already high on REQ entry is accepted on the first REQ cycle.
- WAIT_DOWN: wait configured_i=0 -> WAIT_UP.
- WAIT_UP: wait configured_i=1 -> RELEASE.
- RELEASE: fabric_rst_o=1 for RST_CYCLES cycles, then -> IDLE (fabric_rst_o and busy_o 0 on the IDLE cycle).
- boot_i/slot_i ignored outside IDLE/ARM. cfg_ack_i ignored outside REQ. configured_i falling in IDLE is not an error; it is ignored.
- RESET mid-sequence: immediate return to BOOTUP values; error_o cleared.

## Timing
- boot_i high at cycles 0..HOLD_CYCLES-1 (rearmed): cfg_req_o and fabric_rst_o high from cycle HOLD_CYCLES.
- Ack sampled at cycle k: cfg_req_o low at k+1.
- configured_i sampled high in WAIT_UP at cycle m: fabric_rst_o low at m+1+RST_CYCLES.
- Counters sized $clog2(param+1); saturate, never wrap.

## Configuration
- WARMBOOT_TIMEOUT_EN defined: one timeout counter runs in REQ, WAIT_DOWN, WAIT_UP, cleared on each state entry; reaching TIMEOUT_CYCLES -> ERROR: error_o=1 (sticky until RESET), cfg_req_o 0, then -> RELEASE (fabric released so user logic sees error_o).
- Undefined: no timeout counter, no ERROR state, waits indefinitely, error_o tied 0.

## Structure
- warmboot_pkg: state enum type, default SLOT_W, state encoding constants.
- One sub-module: warmboot_cycle_counter (clear/enable/terminal-count, parameterised width and limit), instantiated for hold, release and timeout counts.

## Test plan
- After RESET, configured_i=1 at cycle 3 -> fabric_rst_o low at cycle 4+8, busy_o 0.
- boot_i high 16 cycles, slot_i=4'h5 -> cfg_req_o=1 at cycle 16, cfg_slot_o=5, last_slot_o=5; ack at cycle 20 -> cfg_req_o 0 at 21.
- boot_i high 15 cycles then low -> no request, state IDLE; boot_i held high after a completed boot -> no second request until boot_i seen low.
- Full cycle: ack, configured_i drops then rises -> fabric_rst_o held throughout, released exactly RST_CYCLES after rise.
- WARMBOOT_TIMEOUT_EN, TIMEOUT_CYCLES=64, configured_i stuck high -> error_o=1 after 64 WAIT_DOWN cycles, fabric released, stays set until RESET.
- RESET asserted in WAIT_UP -> next cycle cfg_req_o 0, fabric_rst_o 1, busy_o 1, error_o 0.

Source files
------------

// File: rtl/warmboot_pkg.sv
// Shared types for the warm-boot sequencer: state encoding and default slot width.
package warmboot_pkg;

    localparam int SLOT_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_BOOTUP    = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ARM       = 3'd2,
        ST_REQ       = 3'd3,
        ST_WAIT_DOWN = 3'd4,
        ST_WAIT_UP   = 3'd5,
        ST_RELEASE   = 3'd6,
        ST_ERROR     = 3'd7
    } wb_state_t;

    function automatic logic is_handshake_state(input wb_state_t st);
        return (st == ST_REQ) || (st == ST_WAIT_DOWN) || (st == ST_WAIT_UP);
    endfunction

endpackage

// File: rtl/warmboot_cycle_counter.sv
// Saturating cycle counter with synchronous clear; term flags the enabled cycle that completes LIMIT counts.
module warmboot_cycle_counter #(
    parameter int LIMIT = 16,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign term = en && (count == LAST);

endmodule

// File: rtl/warmboot_sequencer.sv
// Warm-boot sequencer: qualifies BOOT/SLOT, runs the req/ack and CONFIGURED handshakes, holds fabric reset.
// Optional timeout/ERROR handling is built when WARMBOOT_TIMEOUT_EN is defined.
module warmboot_sequencer
    import warmboot_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int RST_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SLOT_W         = SLOT_W_DEF
) (
    input  logic              UserCLK,
    input  logic              RESET,
    input  logic              boot_i,
    input  logic [SLOT_W-1:0] slot_i,
    output logic              cfg_req_o,
    output logic [SLOT_W-1:0] cfg_slot_o,
    input  logic              cfg_ack_i,
    input  logic              configured_i,
    output logic              fabric_rst_o,
    output logic              busy_o,
    output logic              error_o,
    output logic [SLOT_W-1:0] last_slot_o
);

    wb_state_t state_q, state_d;
    logic      rearm_q;
    logic      latch_slot;
    logic      hold_en, hold_term;
    logic      rel_en, rel_term;
    logic      timeout_hit;

    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            state_q <= ST_BOOTUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Rearm requires boot_i to be seen low in IDLE, so a held request cannot retrigger.
    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            rearm_q <= 1'b0;
        end else if (latch_slot) begin
            rearm_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && !boot_i) begin
            rearm_q <= 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            cfg_slot_o  <= '0;
            last_slot_o <= '0;
        end else if (latch_slot) begin
            cfg_slot_o  <= slot_i;
            last_slot_o <= slot_i;
        end
    end

    assign hold_en = boot_i && (((state_q == ST_IDLE) && rearm_q) || (state_q == ST_ARM));
    assign rel_en  = (state_q == ST_RELEASE);

    warmboot_cycle_counter #(.LIMIT(HOLD_CYCLES)) u_hold_cnt (
        .clk  (UserCLK),
        .rst  (RESET),
        .clr  (!hold_en),
        .en   (hold_en),
        .term (hold_term)
    );

    warmboot_cycle_counter #(.LIMIT(RST_CYCLES)) u_rel_cnt (
        .clk  (UserCLK),
        .rst  (RESET),
        .clr  (!rel_en),
        .en   (rel_en),
        .term (rel_term)
    );

`ifdef WARMBOOT_TIMEOUT_EN
    logic tmo_en;
    logic error_q;

    assign tmo_en = is_handshake_state(state_q);

    // Clearing on any state change restarts the budget for each handshake phase.
    warmboot_cycle_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo_cnt (
        .clk  (UserCLK),
        .rst  (RESET),
        .clr  (!tmo_en || (state_d != state_q)),
        .en   (tmo_en),
        .term (timeout_hit)
    );

    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            error_q <= 1'b0;
        end else if (state_d == ST_ERROR) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error_o     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        latch_slot = 1'b0;
        case (state_q)
            ST_BOOTUP: begin
                if (configured_i) state_d = ST_RELEASE;
            end
            ST_IDLE: begin
                if (boot_i && rearm_q) begin
                    if (hold_term) begin
                        state_d    = ST_REQ;
                        latch_slot = 1'b1;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (!boot_i) begin
                    state_d = ST_IDLE;
                end else if (hold_term) begin
                    state_d    = ST_REQ;
                    latch_slot = 1'b1;
                end
            end
            ST_REQ: begin
                if (cfg_ack_i)        state_d = ST_WAIT_DOWN;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_WAIT_DOWN: begin
                if (!configured_i)    state_d = ST_WAIT_UP;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_WAIT_UP: begin
                if (configured_i)     state_d = ST_RELEASE;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_RELEASE: begin
                if (rel_term) state_d = ST_IDLE;
            end
`ifdef WARMBOOT_TIMEOUT_EN
            ST_ERROR: begin
                state_d = ST_RELEASE;
            end
`endif
            default: begin
                state_d = ST_BOOTUP;
            end
        endcase
    end

    assign cfg_req_o    = (state_q == ST_REQ);
    assign fabric_rst_o = !((state_q == ST_IDLE) || (state_q == ST_ARM));
    assign busy_o       = !((state_q == ST_IDLE) || (state_q == ST_ARM));

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Scoreboard bench for warmboot_sequencer: stimulus queues timestamped expectations, a negedge monitor checks them.
module tb_warmboot_sequencer;

`ifdef WARMBOOT_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 1048576;
`endif

    logic       UserCLK;
    logic       RESET;
    logic       boot_i;
    logic [3:0] slot_i;
    logic       cfg_req_o;
    logic [3:0] cfg_slot_o;
    logic       cfg_ack_i;
    logic       configured_i;
    logic       fabric_rst_o;
    logic       busy_o;
    logic       error_o;
    logic [3:0] last_slot_o;

    warmboot_sequencer #(
        .HOLD_CYCLES    (16),
        .RST_CYCLES     (8),
        .TIMEOUT_CYCLES (TMO),
        .SLOT_W         (4)
    ) dut (
        .UserCLK      (UserCLK),
        .RESET        (RESET),
        .boot_i       (boot_i),
        .slot_i       (slot_i),
        .cfg_req_o    (cfg_req_o),
        .cfg_slot_o   (cfg_slot_o),
        .cfg_ack_i    (cfg_ack_i),
        .configured_i (configured_i),
        .fabric_rst_o (fabric_rst_o),
        .busy_o       (busy_o),
        .error_o      (error_o),
        .last_slot_o  (last_slot_o)
    );

    typedef struct {
        int          at;
        logic [11:0] val;
        logic [11:0] mask;
        string       name;
    } exp_t;

    localparam logic [11:0] M_ALL = 12'hFFF;
    localparam logic [11:0] M_CTL = 12'hD00;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    always @(posedge UserCLK) cyc <= cyc + 1;

    wire [11:0] obs = {cfg_req_o, fabric_rst_o, busy_o, error_o, cfg_slot_o, last_slot_o};

    always @(negedge UserCLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                checks++;
                if ((obs & sb[i].mask) != (sb[i].val & sb[i].mask)) begin
                    errors++;
                    $display("FAIL %s cycle %0d: outputs {req,rst,busy,err,slot,last}=%h required %h (mask %h)",
                             sb[i].name, cyc, obs, sb[i].val, sb[i].mask);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", sb[i].name, sb[i].at, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic exp(input int at, input logic req, input logic rst, input logic busy, input logic err,
                       input logic [3:0] slot, input logic [3:0] last, input logic [11:0] mask, input string name);
        exp_t e;
        e.at   = at;
        e.val  = {req, rst, busy, err, slot, last};
        e.mask = mask;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic until_cyc(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        int r, b, c, d, last_t;
`ifdef WARMBOOT_TIMEOUT_EN
        int g, e;
`endif
        RESET        = 1'b1;
        boot_i       = 1'b0;
        slot_i       = 4'h0;
        cfg_ack_i    = 1'b0;
        configured_i = 1'b0;
        step();
        step();

        // Power-up: reset values, then release exactly RST_CYCLES after CONFIGURED.
        r = cyc;
        RESET = 1'b0;
        exp(r,      0, 1, 1, 0, 4'h0, 4'h0, M_ALL, "reset_values");
        exp(r + 11, 0, 1, 1, 0, 4'h0, 4'h0, M_ALL, "bootup_rst_held");
        exp(r + 12, 0, 0, 0, 0, 4'h0, 4'h0, M_ALL, "bootup_released");
        until_cyc(r + 3);
        configured_i = 1'b1;

        // Qualified request with slot 5, full reload handshake, then boot_i kept high.
        b = r + 14;
        exp(b + 15, 0, 0, 0, 0, 4'h0, 4'h0, M_CTL, "hold_15_no_req");
        exp(b + 16, 1, 1, 1, 0, 4'h5, 4'h5, M_ALL, "req_asserted");
        exp(b + 20, 1, 1, 1, 0, 4'h5, 4'h5, M_ALL, "req_until_ack");
        exp(b + 21, 0, 1, 1, 0, 4'h5, 4'h5, M_ALL, "req_drop_after_ack");
        exp(b + 27, 0, 1, 1, 0, 4'h5, 4'h5, M_ALL, "wait_up_rst_held");
        exp(b + 38, 0, 1, 1, 0, 4'h5, 4'h5, M_ALL, "release_last_cycle");
        exp(b + 39, 0, 0, 0, 0, 4'h5, 4'h5, M_ALL, "release_done");
        exp(b + 58, 0, 0, 0, 0, 4'h5, 4'h5, M_ALL, "no_retrigger_held_boot");
        exp(b + 64, 0, 0, 0, 0, 4'h5, 4'h5, M_ALL, "cfg_drop_in_idle");
        until_cyc(b);
        boot_i = 1'b1;
        slot_i = 4'h5;
        until_cyc(b + 16);
        slot_i = 4'h3;
        until_cyc(b + 20);
        cfg_ack_i = 1'b1;
        until_cyc(b + 21);
        cfg_ack_i = 1'b0;
        until_cyc(b + 24);
        configured_i = 1'b0;
        until_cyc(b + 30);
        configured_i = 1'b1;
        until_cyc(b + 59);
        boot_i = 1'b0;
        until_cyc(b + 62);
        configured_i = 1'b0;
        until_cyc(b + 65);
        configured_i = 1'b1;

        // One cycle short of the hold time: no request.
        c = b + 66;
        exp(c + 16, 0, 0, 0, 0, 4'h5, 4'h5, M_ALL, "short_hold_no_req");
        exp(c + 17, 0, 0, 0, 0, 4'h5, 4'h5, M_ALL, "short_hold_idle");
        until_cyc(c);
        boot_i = 1'b1;
        slot_i = 4'h9;
        until_cyc(c + 15);
        boot_i = 1'b0;

        // Ack already high on REQ entry, then RESET in WAIT_UP.
        d = c + 18;
        exp(d + 16, 1, 1, 1, 0, 4'hA, 4'hA, M_ALL, "req_slot_a");
        exp(d + 17, 0, 1, 1, 0, 4'hA, 4'hA, M_ALL, "early_ack_accepted");
        exp(d + 20, 0, 1, 1, 0, 4'hA, 4'hA, M_ALL, "wait_up_second");
        exp(d + 22, 0, 1, 1, 0, 4'h0, 4'h0, M_ALL, "reset_mid_sequence");
        exp(d + 25, 0, 1, 1, 0, 4'h0, 4'h0, M_ALL, "bootup_after_reset");
        until_cyc(d);
        boot_i = 1'b1;
        slot_i = 4'hA;
        until_cyc(d + 10);
        cfg_ack_i = 1'b1;
        until_cyc(d + 16);
        boot_i = 1'b0;
        until_cyc(d + 17);
        cfg_ack_i = 1'b0;
        until_cyc(d + 18);
        configured_i = 1'b0;
        until_cyc(d + 21);
        RESET = 1'b1;
        until_cyc(d + 22);
        RESET = 1'b0;
        last_t = d + 27;
        until_cyc(last_t);

`ifdef WARMBOOT_TIMEOUT_EN
        // CONFIGURED never drops: timeout in WAIT_DOWN, sticky error until RESET.
        g = cyc;
        e = g + 10;
        configured_i = 1'b1;
        exp(e + 16, 1, 1, 1, 0, 4'h2, 4'h2, M_ALL, "tmo_req");
        exp(e + 80, 0, 1, 1, 0, 4'h2, 4'h2, M_ALL, "tmo_not_yet");
        exp(e + 81, 0, 1, 1, 1, 4'h2, 4'h2, M_ALL, "tmo_error_set");
        exp(e + 90, 0, 0, 0, 1, 4'h2, 4'h2, M_ALL, "tmo_fabric_released");
        exp(e + 93, 0, 1, 1, 0, 4'h0, 4'h0, M_ALL, "tmo_error_cleared");
        until_cyc(e);
        boot_i    = 1'b1;
        slot_i    = 4'h2;
        cfg_ack_i = 1'b1;
        until_cyc(e + 16);
        boot_i = 1'b0;
        until_cyc(e + 92);
        RESET = 1'b1;
        until_cyc(e + 93);
        RESET     = 1'b0;
        cfg_ack_i = 1'b0;
        last_t = e + 95;
        until_cyc(last_t);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
